// File: rtl/gpu_pkg.sv
// gpu_pkg: shared types and defaults for the GPU framebuffer fill engine.
//   - fill_state_t : engine FSM states (IDLE / FILL / DONE)
//   - GPU_*        : default framebuffer geometry and bus widths
//   - color_t      : 16-bit colour as four 4-bit nibbles
package gpu_pkg;

    localparam int GPU_FB_W    = 640;
    localparam int GPU_FB_H    = 400;
    localparam int GPU_COORD_W = 10;
    localparam int GPU_DATA_W  = 16;
    localparam int GPU_ADDR_W  = 18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

    // Pixel nibble layout, MSB first: unused nibble, red, green, blue.
    typedef struct packed {
        logic [3:0] x;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } color_t;

endpackage

// File: rtl/gpu_rect_fill_if.sv
// gpu_rect_fill_if: command handshake plus GPU-SRAM write port of the fill engine.
//   master : command source / SRAM side (drives command, observes bus)
//   slave  : fill engine (accepts command, drives SRAM strobes)
// Signals: I_CMD_VALID/O_CMD_READY handshake, I_X0..I_Y1 inclusive corners,
//          I_COLOR/I_COLOR_ALT fill colours, O_DONE completion pulse,
//          O_GPU_ADDR/O_GPU_DATA/O_GPU_WRITE/O_GPU_READ SRAM port.
interface gpu_rect_fill_if #(
    parameter int COORD_W = 10,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 18
);
    logic               I_CMD_VALID;
    logic               O_CMD_READY;
    logic [COORD_W-1:0] I_X0;
    logic [COORD_W-1:0] I_Y0;
    logic [COORD_W-1:0] I_X1;
    logic [COORD_W-1:0] I_Y1;
    logic [DATA_W-1:0]  I_COLOR;
    logic [DATA_W-1:0]  I_COLOR_ALT;
    logic               O_DONE;
    logic [ADDR_W-1:0]  O_GPU_ADDR;
    logic [DATA_W-1:0]  O_GPU_DATA;
    logic               O_GPU_WRITE;
    logic               O_GPU_READ;

    modport master (
        output I_CMD_VALID, I_X0, I_Y0, I_X1, I_Y1, I_COLOR, I_COLOR_ALT,
        input  O_CMD_READY, O_DONE, O_GPU_ADDR, O_GPU_DATA, O_GPU_WRITE, O_GPU_READ
    );

    modport slave (
        input  I_CMD_VALID, I_X0, I_Y0, I_X1, I_Y1, I_COLOR, I_COLOR_ALT,
        output O_CMD_READY, O_DONE, O_GPU_ADDR, O_GPU_DATA, O_GPU_WRITE, O_GPU_READ
    );
endinterface

// File: rtl/gpu_rect_walker.sv
// gpu_rect_walker: raster walker over a clipped rectangle.
// Holds x / y / row-base counters; the SRAM address is row-base + x, so the
// only multiply is the one-off Y0*FB_W at load time.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_load                capture X0/Y0/x1c/y1c and start at (X0,Y0)
//   i_step                advance one pixel (low = hold, i.e. stall)
//   i_x0,i_y0,i_x1c,i_y1c rectangle start and clipped end corners
//   o_addr                framebuffer address of the current pixel
//   o_last                current pixel is (x1c,y1c)
//   o_par                 (x ^ y) & 1 of the current pixel
module gpu_rect_walker #(
    parameter int FB_W    = 640,
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 18
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [COORD_W-1:0] i_x0,
    input  logic [COORD_W-1:0] i_y0,
    input  logic [COORD_W-1:0] i_x1c,
    input  logic [COORD_W-1:0] i_y1c,
    output logic [ADDR_W-1:0]  o_addr,
    output logic               o_last,
    output logic               o_par
);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(FB_W);

    logic [COORD_W-1:0] r_x, r_y, r_x0, r_x1c, r_y1c;
    logic [ADDR_W-1:0]  r_rowbase;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x       <= '0;
            r_y       <= '0;
            r_x0      <= '0;
            r_x1c     <= '0;
            r_y1c     <= '0;
            r_rowbase <= '0;
        end else if (i_load) begin
            r_x       <= i_x0;
            r_y       <= i_y0;
            r_x0      <= i_x0;
            r_x1c     <= i_x1c;
            r_y1c     <= i_y1c;
            r_rowbase <= ADDR_W'(i_y0) * ROW_STRIDE;
        end else if (i_step) begin
            if (r_x == r_x1c) begin
                // Row wrap. Stepping past the final pixel is harmless: the
                // owner leaves FILL on that same edge.
                r_x       <= r_x0;
                r_y       <= r_y + 1'b1;
                r_rowbase <= r_rowbase + ROW_STRIDE;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign o_addr = r_rowbase + ADDR_W'(r_x);
    assign o_last = (r_x == r_x1c) && (r_y == r_y1c);
    assign o_par  = r_x[0] ^ r_y[0];

endmodule

// File: rtl/gpu_rect_fill.sv
// gpu_rect_fill: solid-colour rectangle fill engine for the GPU-SRAM port.
// Accepts one rectangle command, clips it to FB_W x FB_H and writes one pixel
// per clock while I_VIDEO_ON is low; pulses O_DONE when finished.
// Ports:
//   I_CLK, I_RST_N  clock, async active-low reset
//   I_VIDEO_ON      display scanning: SRAM writes are held off
//   bus (slave)     command handshake and SRAM write port (gpu_rect_fill_if)
// Optional feature: define GPU_RECT_FILL_CHECKER_EN for a checkerboard fill
// (I_COLOR_ALT on pixels where (x ^ y) is odd, absolute coordinates).
module gpu_rect_fill
    import gpu_pkg::*;
#(
    parameter int FB_W    = GPU_FB_W,
    parameter int FB_H    = GPU_FB_H,
    parameter int COORD_W = GPU_COORD_W,
    parameter int DATA_W  = GPU_DATA_W,
    parameter int ADDR_W  = GPU_ADDR_W
) (
    input  logic            I_CLK,
    input  logic            I_RST_N,
    input  logic            I_VIDEO_ON,
    gpu_rect_fill_if.slave  bus
);
    localparam logic [COORD_W-1:0] XMAX = COORD_W'(FB_W - 1);
    localparam logic [COORD_W-1:0] YMAX = COORD_W'(FB_H - 1);

    fill_state_t        r_state;
    logic               r_ready;
    logic               r_done;
    logic               r_write;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic [DATA_W-1:0]  r_color;

    logic [COORD_W-1:0] w_x1c, w_y1c;
    logic               w_accept, w_empty, w_load, w_step, w_last;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_pix;

`ifdef GPU_RECT_FILL_CHECKER_EN
    logic [DATA_W-1:0]  r_color_alt;
    logic               w_par;
`endif

    // r_ready is high exactly in IDLE, so it doubles as the accept qualifier.
    assign w_accept = bus.I_CMD_VALID && r_ready;
    assign w_x1c    = (bus.I_X1 > XMAX) ? XMAX : bus.I_X1;
    assign w_y1c    = (bus.I_Y1 > YMAX) ? YMAX : bus.I_Y1;
    // Also covers X0/Y0 beyond the framebuffer, since x1c/y1c are clipped.
    assign w_empty  = (bus.I_X0 > w_x1c) || (bus.I_Y0 > w_y1c);
    assign w_load   = w_accept && !w_empty;
    assign w_step   = (r_state == ST_FILL) && !I_VIDEO_ON;

    gpu_rect_walker #(
        .FB_W    (FB_W),
        .COORD_W (COORD_W),
        .ADDR_W  (ADDR_W)
    ) u_walker (
        .i_clk   (I_CLK),
        .i_rst_n (I_RST_N),
        .i_load  (w_load),
        .i_step  (w_step),
        .i_x0    (bus.I_X0),
        .i_y0    (bus.I_Y0),
        .i_x1c   (w_x1c),
        .i_y1c   (w_y1c),
        .o_addr  (w_addr),
        .o_last  (w_last),
`ifdef GPU_RECT_FILL_CHECKER_EN
        .o_par   (w_par)
`else
        .o_par   ()
`endif
    );

`ifdef GPU_RECT_FILL_CHECKER_EN
    assign w_pix = w_par ? r_color_alt : r_color;
`else
    assign w_pix = r_color;
`endif

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_color     <= '0;
`ifdef GPU_RECT_FILL_CHECKER_EN
            r_color_alt <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_write <= 1'b0;
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        r_color <= bus.I_COLOR;
`ifdef GPU_RECT_FILL_CHECKER_EN
                        r_color_alt <= bus.I_COLOR_ALT;
`endif
                        r_state <= w_empty ? ST_DONE : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (!I_VIDEO_ON) begin
                        r_write <= 1'b1;
                        r_addr  <= w_addr;
                        r_data  <= w_pix;
                        if (w_last) r_state <= ST_DONE;
                    end else begin
                        // Stall: address/data hold, walker holds too.
                        r_write <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_write <= 1'b0;
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_write <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.O_CMD_READY = r_ready;
    assign bus.O_DONE      = r_done;
    assign bus.O_GPU_ADDR  = r_addr;
    assign bus.O_GPU_DATA  = r_data;
    assign bus.O_GPU_WRITE = r_write;
    assign bus.O_GPU_READ  = 1'b0;

endmodule
